// File: rtl/sram_en_sequencer_if.sv
// Control/status bundle between the enable sequencer and the block that owns restart/hold.
// The sequencer takes the slave side; the controlling block (or a bench) takes the master side.
interface sram_en_sequencer_if #(
  parameter int NUM_CH = 2
);
  logic              iRestart;
  logic              iHold;
  logic [NUM_CH-1:0] oAdaptor_en;
  logic              oAllReady;
  logic              oBusy;

  modport master (
    output iRestart,
    output iHold,
    input  oAdaptor_en,
    input  oAllReady,
    input  oBusy
  );

  modport slave (
    input  iRestart,
    input  iHold,
    output oAdaptor_en,
    output oAllReady,
    output oBusy
  );
endinterface

// File: rtl/sram_en_sequencer.sv
// Staggered per-channel SRAM adaptor enables after a start delay; all outputs registered, no backpressure.
// Define SRAM_EN_WINDOW_EN to drop all enables EN_WINDOW cycles after the last one rises (DONE state).
module sram_en_sequencer #(
  parameter int CNT_W     = 8,
  parameter int NUM_CH    = 2,
  parameter int START_DLY = 4,
  parameter int STAGGER   = 2,
  parameter int EN_WINDOW = 41
) (
  input  logic                  iClock,
  input  logic                  iRst,
  sram_en_sequencer_if.slave    bus
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CNT_W-1:0] C_START     = CNT_W'(START_DLY);
  localparam logic [CNT_W-1:0] C_STG_LAST  = CNT_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0] C_IDX_FIRST = IDX_W'(1);
  localparam logic [NUM_CH-1:0] C_CH0      = NUM_CH'(1);
  localparam bit               ALL_AT_ONCE = (NUM_CH == 1) || (STAGGER == 0);

  // Every delay must fit the counter, otherwise a compare would never match.
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("sram_en_sequencer: NUM_CH must be 1..16");
  end
  if (START_DLY < 0 || START_DLY >= (1 << CNT_W)) begin : g_bad_start
    $error("sram_en_sequencer: START_DLY does not fit in CNT_W bits");
  end
  if (STAGGER < 0 || STAGGER >= (1 << CNT_W)) begin : g_bad_stagger
    $error("sram_en_sequencer: STAGGER does not fit in CNT_W bits");
  end
  if (EN_WINDOW < 1 || EN_WINDOW >= (1 << CNT_W)) begin : g_bad_window
    $error("sram_en_sequencer: EN_WINDOW must be >= 1 and fit in CNT_W bits");
  end

`ifdef SRAM_EN_WINDOW_EN
  localparam logic [CNT_W-1:0] C_WIN_LAST = CNT_W'(EN_WINDOW - 1);

  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,
    S_STAGGER = 2'd1,
    S_RUN     = 2'd2,
    S_DONE    = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,
    S_STAGGER = 2'd1,
    S_RUN     = 2'd2
  } state_t;
`endif

  state_t             r_state,  w_state_nxt;
  logic [CNT_W-1:0]   r_count,  w_count_nxt;
  logic [IDX_W-1:0]   r_idx,    w_idx_nxt;
  logic [NUM_CH-1:0]  r_en,     w_en_nxt;
  logic               r_all,    w_all_nxt;
  logic               r_busy,   w_busy_nxt;

  always_ff @(posedge iClock or posedge iRst) begin
    if (iRst) begin
      r_state <= S_WAIT;
      r_count <= '0;
      r_idx   <= '0;
      r_en    <= '0;
      r_all   <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_idx   <= w_idx_nxt;
      r_en    <= w_en_nxt;
      r_all   <= w_all_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Restart outranks hold; hold freezes everything by keeping the defaults.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_idx_nxt   = r_idx;
    w_en_nxt    = r_en;
    w_all_nxt   = r_all;
    w_busy_nxt  = r_busy;

    if (bus.iRestart) begin
      w_state_nxt = S_WAIT;
      w_count_nxt = '0;
      w_idx_nxt   = '0;
      w_en_nxt    = '0;
      w_all_nxt   = 1'b0;
      w_busy_nxt  = 1'b1;
    end else if (!bus.iHold) begin
      case (r_state)
        S_WAIT: begin
          if (r_count == C_START) begin
            w_count_nxt = '0;
            if (ALL_AT_ONCE) begin
              w_en_nxt    = '1;
              w_all_nxt   = 1'b1;
              w_busy_nxt  = 1'b0;
              w_state_nxt = S_RUN;
            end else begin
              w_en_nxt    = r_en | C_CH0;
              w_idx_nxt   = C_IDX_FIRST;
              w_state_nxt = S_STAGGER;
            end
          end else begin
            w_count_nxt = r_count + CNT_W'(1);
          end
        end

        S_STAGGER: begin
          if (r_count == C_STG_LAST) begin
            w_count_nxt = '0;
            w_en_nxt    = r_en | (C_CH0 << r_idx);
            if (r_idx == C_IDX_LAST) begin
              w_all_nxt   = 1'b1;
              w_busy_nxt  = 1'b0;
              w_state_nxt = S_RUN;
            end else begin
              w_idx_nxt = r_idx + IDX_W'(1);
            end
          end else begin
            w_count_nxt = r_count + CNT_W'(1);
          end
        end

`ifdef SRAM_EN_WINDOW_EN
        S_RUN: begin
          if (r_count == C_WIN_LAST) begin
            w_count_nxt = '0;
            w_en_nxt    = '0;
            w_all_nxt   = 1'b0;
            w_state_nxt = S_DONE;
          end else begin
            w_count_nxt = r_count + CNT_W'(1);
          end
        end

        S_DONE: ;
`else
        S_RUN: ;
`endif

        default: begin
          w_state_nxt = S_WAIT;
          w_count_nxt = '0;
          w_idx_nxt   = '0;
          w_en_nxt    = '0;
          w_all_nxt   = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      endcase
    end
  end

  assign bus.oAdaptor_en = r_en;
  assign bus.oAllReady   = r_all;
  assign bus.oBusy       = r_busy;

endmodule

// File: tb/tb_sram_en_sequencer.sv
// Bench for sram_en_sequencer: three parameter sets driven in lockstep, a hand-written vector
// table, corner sequences, and random restart/hold/reset checked against an edge-count model.
module tb_sram_en_sequencer;

  logic clk;
  logic rst;
  logic restart;
  logic hold;

  int t;
  int n_vec;
  int n_err;

  sram_en_sequencer_if #(.NUM_CH(2)) if_a ();
  sram_en_sequencer_if #(.NUM_CH(4)) if_b ();
  sram_en_sequencer_if #(.NUM_CH(3)) if_c ();

  assign if_a.iRestart = restart;
  assign if_a.iHold    = hold;
  assign if_b.iRestart = restart;
  assign if_b.iHold    = hold;
  assign if_c.iRestart = restart;
  assign if_c.iHold    = hold;

  sram_en_sequencer #(.CNT_W(8), .NUM_CH(2), .START_DLY(4), .STAGGER(2), .EN_WINDOW(41)) dut_a (
    .iClock(clk), .iRst(rst), .bus(if_a.slave));
  sram_en_sequencer #(.CNT_W(8), .NUM_CH(4), .START_DLY(0), .STAGGER(0), .EN_WINDOW(41)) dut_b (
    .iClock(clk), .iRst(rst), .bus(if_b.slave));
  sram_en_sequencer #(.CNT_W(6), .NUM_CH(3), .START_DLY(2), .STAGGER(3), .EN_WINDOW(5)) dut_c (
    .iClock(clk), .iRst(rst), .bus(if_c.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       hold;
    logic       restart;
    logic [1:0] en;
    logic       all;
    logic       busy;
  } vec_t;

  vec_t tbl [0:21];

  // Channel k is up once the block has seen enough un-held edges since (re)start.
  function automatic void model(input int nch, input int sd, input int st, input int win,
                                input int tt, output logic [15:0] en,
                                output logic all, output logic busy);
    int   last;
    int   rise;
    logic windowed;
`ifdef SRAM_EN_WINDOW_EN
    windowed = 1'b1;
`else
    windowed = 1'b0;
`endif
    last = (st == 0) ? sd + 1 : sd + 1 + st * (nch - 1);
    en = '0;
    for (int k = 0; k < nch; k++) begin
      rise  = (st == 0) ? sd + 1 : sd + 1 + st * k;
      en[k] = (tt >= rise) && !(windowed && tt >= last + win);
    end
    all  = (tt >= last) && !(windowed && tt >= last + win);
    busy = (tt < last);
  endfunction

  task automatic cmp(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d: got en/all/busy=%h expected %h", name, t, act, exp);
    end
  endtask

  function automatic logic [17:0] act_a();
    return {16'(if_a.oAdaptor_en), if_a.oAllReady, if_a.oBusy};
  endfunction

  task automatic check_all(input string tag);
    logic [15:0] e;
    logic        a;
    logic        b;
    model(2, 4, 2, 41, t, e, a, b);
    cmp({tag, "/a"}, act_a(), {e, a, b});
    model(4, 0, 0, 41, t, e, a, b);
    cmp({tag, "/b"}, {16'(if_b.oAdaptor_en), if_b.oAllReady, if_b.oBusy}, {e, a, b});
    model(3, 2, 3, 5, t, e, a, b);
    cmp({tag, "/c"}, {16'(if_c.oAdaptor_en), if_c.oAllReady, if_c.oBusy}, {e, a, b});
  endtask

  task automatic step();
    @(posedge clk);
    if (rst || restart) t = 0;
    else if (!hold)     t = t + 1;
    #1;
  endtask

  initial begin
    logic [17:0] exp_win;
    rst = 1'b1; restart = 1'b0; hold = 1'b0;
    t = 0; n_vec = 0; n_err = 0;

    // Default parameters: hold over edges 2..4, restart at 12, restart+hold at 21.
    tbl[0]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 2'b01, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 2'b01, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 2'b11, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 2'b11, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 2'b01, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 2'b01, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 2'b11, 1'b1, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 2'b11, 1'b1, 1'b0};
    tbl[20] = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b1};
    tbl[21] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b1};

    #3;
    check_all("reset");
    #4 rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      hold    = tbl[i].hold;
      restart = tbl[i].restart;
      step();
      cmp($sformatf("tbl%0d", i), act_a(),
          {14'h0, tbl[i].en, tbl[i].all, tbl[i].busy});
      check_all($sformatf("tbl%0d_model", i));
    end
    hold = 1'b0; restart = 1'b0;

    // Asynchronous reset in the middle of the stagger phase.
    restart = 1'b1; step(); restart = 1'b0;
    for (int i = 0; i < 6; i++) begin step(); check_all("pre_arst"); end
    cmp("pre_arst_ch0", act_a(), {16'h1, 1'b0, 1'b1});
    #4 rst = 1'b1;
    #1 t = 0;
    cmp("arst_immediate", act_a(), {16'h0, 1'b0, 1'b1});
    check_all("arst");
    step(); check_all("arst_held");
    step(); check_all("arst_held");
    #3 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin step(); check_all("post_arst"); end
    cmp("post_arst_ch0", act_a(), {16'h1, 1'b0, 1'b1});
    step(); step();
    cmp("post_arst_all", act_a(), {16'h3, 1'b1, 1'b0});

    // Long run to observe the enable window (or its absence).
    restart = 1'b1; step(); restart = 1'b0;
    check_all("win_start");
`ifdef SRAM_EN_WINDOW_EN
    exp_win = {16'h0, 1'b0, 1'b0};
`else
    exp_win = {16'h3, 1'b1, 1'b0};
`endif
    for (int n = 1; n <= 150; n++) begin
      step();
      check_all("win");
      if (n == 47)  cmp("win_edge47",  act_a(), {16'h3, 1'b1, 1'b0});
      if (n == 48)  cmp("win_edge48",  act_a(), exp_win);
      if (n == 148) cmp("win_edge148", act_a(), exp_win);
    end

    // Random restart/hold with occasional mid-cycle asynchronous reset.
    for (int n = 0; n < 700; n++) begin
      restart = ($urandom_range(0, 39) == 0);
      hold    = ($urandom_range(0, 4) == 0);
      step();
      check_all("rnd");
      if ($urandom_range(0, 149) == 0) begin
        #4 rst = 1'b1;
        #1 t = 0;
        check_all("rnd_arst");
        #2 rst = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
